// File: rtl/if_prefetch_unit_pkg.sv
// Shared pipeline-buffer definitions: prefetch queue entry layout and sizing helpers.
package if_prefetch_unit_pkg;

    localparam int FQ_DEPTH_DEFAULT = 4;
    localparam int FQ_PC_W_DEFAULT  = 9;
    localparam int FQ_INS_W_DEFAULT = 32;

    // Entry layout for the default configuration; parametrised users build the same shape locally.
    typedef struct packed {
        logic [FQ_PC_W_DEFAULT-1:0]  pc;
        logic [FQ_INS_W_DEFAULT-1:0] instr;
    } fq_entry_t;

    function automatic int fq_count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/if_prefetch_unit_sync_fifo.sv
// Synchronous FIFO with clear; head output holds its last value while empty.
module if_prefetch_unit_sync_fifo
    import if_prefetch_unit_pkg::*;
#(
    parameter type elem_t = logic [31:0],
    parameter int  DEPTH  = FQ_DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  elem_t                        wdata,
    input  logic                         pop,
    output elem_t                        rdata,
    output logic                         full,
    output logic                         empty,
    output logic [fq_count_w(DEPTH)-1:0] count
);

    localparam int CNT_W = fq_count_w(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);

    elem_t             mem_q [DEPTH];
    elem_t             last_q;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = count_q;
    assign rdata   = empty ? last_q : mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            last_q   <= rdata;
        end
    end

    // Storage is not reset; the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!reset && !clear && do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: PC generation, synchronous imem access, prefetch queue to decode.
module if_prefetch_unit
    import if_prefetch_unit_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter int              INS_W    = 32,
    parameter int              DEPTH    = FQ_DEPTH_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         imem_req,
    output logic [PC_W-1:0]              imem_addr,
    input  logic [INS_W-1:0]             imem_rdata,
    input  logic                         redirect,
    input  logic [PC_W-1:0]              redirect_pc,
    output logic                         id_valid,
    input  logic                         id_ready,
    output logic [INS_W-1:0]             id_instr,
    output logic [PC_W-1:0]              id_pc,
    output logic [fq_count_w(DEPTH)-1:0] count
);

    localparam int CNT_W = fq_count_w(DEPTH);
    localparam int CMP_W = CNT_W + 1;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] instr;
    } entry_t;

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic             inflight_q, inflight_d;
    logic             pop, fifo_empty, fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic [CMP_W-1:0] occupancy, limit;
    entry_t           push_entry, head_entry;

    assign pop = id_valid && id_ready;

    // A slot is reserved for every word in flight, so a returning word always fits.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign limit     = CMP_W'(DEPTH) + {{CNT_W{1'b0}}, pop};
    assign imem_req  = !reset && !redirect && (occupancy < limit);
    assign imem_addr = fetch_pc_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
        end else if (imem_req) begin
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + PC_W'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    assign push_entry = '{pc: inflight_pc_q, instr: imem_rdata};

    if_prefetch_unit_sync_fifo #(
        .elem_t (entry_t),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (redirect),
        .push  (inflight_q),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign id_valid = !fifo_empty;
    assign id_instr = head_entry.instr;
    assign id_pc    = head_entry.pc;
    assign count    = fifo_count;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: streaming, stall, redirect, PC wrap and mid-run reset.
module tb_if_prefetch_unit;

    localparam int PC_W  = 9;
    localparam int INS_W = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic [INS_W-1:0] imem_rdata = '0;
    logic             redirect = 1'b0;
    logic [PC_W-1:0]  redirect_pc = '0;
    logic             id_valid;
    logic             id_ready = 1'b0;
    logic [INS_W-1:0] id_instr;
    logic [PC_W-1:0]  id_pc;
    logic [CNT_W-1:0] count;

    int errors = 0;
    int checks = 0;
    logic [PC_W-1:0] exp_pc;

    if_prefetch_unit #(
        .PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH), .RESET_PC('0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: word at PC k is A000_0000 + k.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'hA000_0000 + {23'b0, imem_addr};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string name, input logic [PC_W-1:0] pc);
        logic [INS_W-1:0] exp_instr;
        exp_instr = 32'hA000_0000 + {23'b0, pc};
        checks++;
        if (id_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid got=%0b exp=1", name, id_valid);
        end
        checks++;
        if (id_pc !== pc) begin
            errors++;
            $display("FAIL %s_pc got=%h exp=%h", name, id_pc, pc);
        end
        checks++;
        if (id_instr !== exp_instr) begin
            errors++;
            $display("FAIL %s_instr got=%h exp=%h", name, id_instr, exp_instr);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", id_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
        checks++; if (imem_addr !== 9'h000) begin errors++; $display("FAIL reset_addr got=%h exp=000", imem_addr); end
        checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", id_instr); end
        checks++; if (id_pc !== 9'h000) begin errors++; $display("FAIL reset_pc got=%h exp=000", id_pc); end
    endtask

    task automatic test_stream;
        tick();
        reset = 1'b0;
        id_ready = 1'b1;
        exp_pc = 9'h000;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stream_first_req got=%0b exp=1", imem_req); end
                checks++; if (imem_addr !== 9'h000) begin errors++; $display("FAIL stream_first_addr got=%h exp=000", imem_addr); end
            end
            if (c < 2) begin
                checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL stream_latency c=%0d got=%0b exp=0", c, id_valid); end
            end else begin
                check_head("stream", exp_pc);
                exp_pc = exp_pc + 9'd4;
            end
            tick();
        end
    endtask

    task automatic test_stall;
        id_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_head("stall_hold", exp_pc);
            if (k == 9) begin
                checks++; if (count !== 3'd4) begin errors++; $display("FAIL stall_count got=%0d exp=4", count); end
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req got=%0b exp=0", imem_req); end
            end
            tick();
        end
        id_ready = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL release_req got=%0b exp=1", imem_req); end
        check_head("release", exp_pc);
        exp_pc = exp_pc + 9'd4;
        tick();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_head("after_stall", exp_pc);
            exp_pc = exp_pc + 9'd4;
            tick();
        end
    endtask

    task automatic test_redirect;
        redirect = 1'b1;
        redirect_pc = 9'h0A6;
        @(negedge clk);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL redir_pre_count got=%0d exp=3", count); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req got=%0b exp=0", imem_req); end
        tick();
        redirect = 1'b0;
        @(negedge clk);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL redir_count got=%0d exp=0", count); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_valid1 got=%0b exp=0", id_valid); end
        checks++; if (imem_addr !== 9'h0A4) begin errors++; $display("FAIL redir_addr got=%h exp=0a4", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL redir_target_req got=%0b exp=1", imem_req); end
        tick();
        @(negedge clk);
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_valid2 got=%0b exp=0", id_valid); end
        tick();
        exp_pc = 9'h0A4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_head("redir_seq", exp_pc);
            exp_pc = exp_pc + 9'd4;
            tick();
        end
    endtask

    task automatic test_redirect_wrap;
        redirect = 1'b1;
        redirect_pc = 9'h1F3;
        @(negedge clk);
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL wrap_redir_pop got=%0b exp=1", id_valid); end
        tick();
        redirect = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL wrap_stale k=%0d pc=%h got=%0b exp=0", k, id_pc, id_valid); end
            tick();
        end
        exp_pc = 9'h1F0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_head("wrap_seq", exp_pc);
            exp_pc = exp_pc + 9'd4;
            tick();
        end
    endtask

    task automatic test_reset_inflight;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req got=%0b exp=1", imem_req); end
        tick();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%0b exp=0", imem_req); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", id_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (imem_addr !== 9'h000) begin errors++; $display("FAIL rst_addr got=%h exp=000", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_first_req got=%0b exp=1", imem_req); end
        tick();
        @(negedge clk);
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid1 got=%0b exp=0", id_valid); end
        tick();
        @(negedge clk);
        check_head("rst_first", 9'h000);
        tick();
        @(negedge clk);
        check_head("rst_second", 9'h004);
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_wrap();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_prefetch_unit.md
# if_prefetch_unit

Parametrised instruction-fetch front end with a prefetch queue. It generates the fetch PC, drives the synchronous instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. It hands them to decode over a valid/ready handshake, and flushes on branch/jump redirects. It replaces the fixed PC register, PC+4 adder and single IF/ID latch with a decoupled, stall-tolerant fetch stage.

## Interface
- PC_W, 9, program counter / instruction memory address width
- INS_W, 32, instruction width
- DEPTH, 4, prefetch FIFO entries; legal range is 2 to 16
- RESET_PC, 0, fetch address after reset
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  read enable to instruction memory
- imem_addr  out  PC_W  read address; equals the current fetch PC
- imem_rdata  in  INS_W  read data; valid the cycle after a request
- redirect  in  1  flush and restart fetch; from the branch unit in EX
- redirect_pc  in  PC_W  restart target
- id_valid  out  1  head of FIFO holds an instruction
- id_ready  in  1  decode accepts the head; low means stall
- id_instr  out  INS_W  head instruction
- id_pc  out  PC_W  PC of the head instruction
- count  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- State: fetch_pc, inflight flag with inflight_pc, FIFO storage, rd/wr pointers, count.
- Pop: occurs when id_valid && id_ready.
- Issue rule: imem_req = !reset && !redirect && (count + inflight < DEPTH + pop).
  - Guarantees every returned word has a free slot.
  - The FIFO never overflows.
- On issue:
  - inflight <= 1
  - inflight_pc <= fetch_pc
  - fetch_pc <= fetch_pc + 4, modulo 2^PC_W; wrap from max to 0 is legal
- If no issue occurs: inflight <= 0.
- Push: when inflight is 1, the entry {inflight_pc, imem_rdata} is written at the FIFO tail.
- Redirect has priority over everything in its cycle:
  - count, pointers and inflight are cleared; the pop and the push in that cycle are discarded.
  - fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00}; the low bits are forced to zero.
  - No request is issued that cycle.
  - A pop coinciding with redirect counts as accepted by decode. The bench must not expect that instruction again.
- Simultaneous push and pop: count is unchanged; pointers advance independently and wrap modulo DEPTH.
- Empty: id_valid = 0. id_instr and id_pc hold the last head value; they carry no meaning.
- Full with no pop: no request; fetch_pc holds.

## Timing
- Reset values:
  - id_valid 0, count 0, imem_req 0, imem_addr RESET_PC, inflight 0.
  - id_instr and id_pc are 0.
- Reset asserted mid-operation: all state is cleared in that cycle, and any data returning next cycle is ignored.
- Fetch latency:
  - Request in cycle R, data sampled in R+1, id_valid high in R+2.
  - There is no bypass from imem_rdata to id_instr.
- After reset deasserts:
  - First request at cycle 0, for RESET_PC.
  - First id_valid at cycle 2.
- Redirect asserted in cycle N:
  - id_valid is 0 from N+1.
  - Request for the target in N+1; target instruction valid at N+3.
  - Redirect penalty is 3 cycles.
- Steady state with id_ready held high: one instruction per cycle for DEPTH >= 2.
- id_ready low for K cycles: the FIFO fills to DEPTH, then imem_req drops.
  - After id_ready returns, the next request issues in the same cycle as the first pop.
- id_valid, id_instr and id_pc are stable while id_valid && !id_ready; no entry is lost or duplicated.

## Structure
- The shared pipeline-buffer package gains:
  - typedef fq_entry_t {pc, instr}, sized from PC_W and INS_W.
  - constant FQ_DEPTH_DEFAULT = 4.
- Sub-module sync_fifo:
  - Parameters: element type / width and DEPTH.
  - Ports: push, pop, clear, full, empty, count.
  - Holds the queue; it is reusable for later decoupled stages.
- Top level holds the fetch PC, issue logic, in-flight tracking and redirect control.

## Test plan
- Reset, then id_ready = 1, memory word at PC k = 32'hA000_0000 + k: id_pc sequence 0, 4, 8 … from cycle 2, one per cycle, instr matching.
- Hold id_ready = 0 for 10 cycles: count saturates at 4, imem_req 0 after the fill, no PC skipped once released.
- Redirect to 9'h0A6 while the FIFO holds 3 entries: count 0 next cycle, imem_addr 9'h0A4, first id_pc 9'h0A4 three cycles after the redirect.
- Redirect coinciding with push and pop: no stale PC ever appears at id_pc after the redirect.
- Fetch runs across 9'h1FC: next id_pc is 9'h000 with no gap.
- Reset pulsed while an instruction is in flight: id_valid 0, count 0, next id_pc is RESET_PC.
